nco_out_buffer: RTL and testbench

- Downstream consumer of the NCO output terminal.
- Captures each 12-bit sample presented with the NCO's valid strobe into a small FIFO.
- Streams samples out over a narrow nibble-wide ready/valid port, MSB nibble first, for pin-limited split I/O.
- Flags a sticky overflow when samples arrive faster than the sink drains them.

---
 rtl/nco_out_buffer.sv | 126 ++++++++++++
 tb/tb_nco_out_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/nco_out_buffer.sv
// NCO output buffer: captures 12-bit samples into a FIFO and streams them out MSB nibble first.
// Optional decimation of incoming samples when NCO_OBUF_DECIM_EN is defined.
module nco_out_buffer #(
    parameter int unsigned DW    = 12,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NW    = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     Clr,
    input  logic                     Vld,
    input  logic [DW-1:0]            Din,
`ifdef NCO_OBUF_DECIM_EN
    input  logic [3:0]               Dec,
`endif
    output logic [NW-1:0]            Dout,
    output logic                     Dvld,
    input  logic                     Drdy,
    output logic                     Sof,
    output logic [$clog2(DEPTH):0]   Level,
    output logic                     Ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned NS = DW / NW;
    localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] IdxLast = IW'(NS - 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e          state_q;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [LW-1:0]   level_q;
    logic [DW-1:0]   sr_q;
    logic [IW-1:0]   idx_q;
    logic            ovf_q;
    logic            sel, full, pop, push, drop;

`ifdef NCO_OBUF_DECIM_EN
    logic [3:0]      dc_q;
    assign sel = (dc_q == 4'd0);
`else
    assign sel = 1'b1;
`endif

    assign full = (level_q == LW'(DEPTH));
    // Pop either to start a sample from idle or to chain the next one after the last nibble.
    assign pop  = !Clr && (level_q != '0) &&
                  ((state_q == StIdle) || (Drdy && (idx_q == IdxLast)));
    assign push = !Clr && Vld && sel && (!full || pop);
    assign drop = !Clr && Vld && sel && !push;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= Din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            sr_q    <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef NCO_OBUF_DECIM_EN
            dc_q    <= 4'd0;
`endif
        end else if (Clr) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            sr_q    <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef NCO_OBUF_DECIM_EN
            dc_q    <= 4'd0;
`endif
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
            if (drop) ovf_q <= 1'b1;
`ifdef NCO_OBUF_DECIM_EN
            if (Vld) dc_q <= (dc_q == Dec) ? 4'd0 : dc_q + 4'd1;
`endif
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        sr_q    <= mem[rptr_q];
                        idx_q   <= '0;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (Drdy) begin
                        if (idx_q != IdxLast) begin
                            sr_q  <= sr_q << NW;
                            idx_q <= idx_q + 1'b1;
                        end else if (pop) begin
                            sr_q  <= mem[rptr_q];
                            idx_q <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs come straight from flops, so an async reset clears them immediately.
    assign Dvld  = (state_q == StSend);
    assign Dout  = sr_q[DW-1 -: NW];
    assign Sof   = Dvld && (idx_q == '0);
    assign Level = level_q;
    assign Ovf   = ovf_q;

endmodule

// File: tb/tb_nco_out_buffer.sv
// Self-checking bench for nco_out_buffer: table-driven streaming vectors plus directed
// sequences for stall, overflow, flush and async reset.
module tb_nco_out_buffer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        Clr, Vld, Drdy;
    logic [11:0] Din;
    logic [3:0]  Dout;
    logic        Dvld, Sof, Ovf;
    logic [3:0]  Level;
`ifdef NCO_OBUF_DECIM_EN
    logic [3:0]  Dec;
`endif

    int checks = 0;
    int passed = 0;

    nco_out_buffer #(.DW(12), .DEPTH(8), .NW(4)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .Clr   (Clr),
        .Vld   (Vld),
        .Din   (Din),
`ifdef NCO_OBUF_DECIM_EN
        .Dec   (Dec),
`endif
        .Dout  (Dout),
        .Dvld  (Dvld),
        .Drdy  (Drdy),
        .Sof   (Sof),
        .Level (Level),
        .Ovf   (Ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [11:0] din;
        logic        drdy;
        logic        exp_dvld;
        logic [3:0]  exp_dout;
        logic        exp_sof;
        logic [3:0]  exp_level;
        logic        exp_ovf;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Drive inputs for the next edge, then return 1 time unit after it.
    task automatic cyc(input logic v, input logic [11:0] d, input logic r, input logic c);
        Vld = v; Din = d; Drdy = r; Clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int budget, input int want, output int n,
                           output logic [11:0] got [16]);
        logic [11:0] cur;
        int k;
        n = 0; k = 0; cur = '0;
        for (int i = 0; i < budget && n < want; i++) begin
            if (Dvld && Drdy) begin
                cur = {cur[7:0], Dout};
                k++;
                if (k == 3) begin
                    got[n] = cur;
                    n++;
                    k = 0;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    vec_t        vecs [13];
    logic [11:0] got [16];
    int          n;

    function automatic vec_t mk(logic v, logic [11:0] d, logic r, logic ev, logic [3:0] eo,
                                logic es, logic [3:0] el, logic eov);
        vec_t t;
        t.vld = v; t.din = d; t.drdy = r; t.exp_dvld = ev; t.exp_dout = eo;
        t.exp_sof = es; t.exp_level = el; t.exp_ovf = eov;
        return t;
    endfunction

    initial begin
        // Single sample A5C, then two back-to-back samples 123/456 with no gap.
        vecs[0]  = mk(1, 12'hA5C, 1, 0, 4'h0, 0, 1, 0);
        vecs[1]  = mk(0, 12'h000, 1, 1, 4'hA, 1, 0, 0);
        vecs[2]  = mk(0, 12'h000, 1, 1, 4'h5, 0, 0, 0);
        vecs[3]  = mk(0, 12'h000, 1, 1, 4'hC, 0, 0, 0);
        vecs[4]  = mk(0, 12'h000, 1, 0, 4'h0, 0, 0, 0);
        vecs[5]  = mk(1, 12'h123, 1, 0, 4'h0, 0, 1, 0);
        vecs[6]  = mk(1, 12'h456, 1, 1, 4'h1, 1, 1, 0);
        vecs[7]  = mk(0, 12'h000, 1, 1, 4'h2, 0, 1, 0);
        vecs[8]  = mk(0, 12'h000, 1, 1, 4'h3, 0, 1, 0);
        vecs[9]  = mk(0, 12'h000, 1, 1, 4'h4, 1, 0, 0);
        vecs[10] = mk(0, 12'h000, 1, 1, 4'h5, 0, 0, 0);
        vecs[11] = mk(0, 12'h000, 1, 1, 4'h6, 0, 0, 0);
        vecs[12] = mk(0, 12'h000, 1, 0, 4'h0, 0, 0, 0);

        rstn = 1'b0; Clr = 1'b0; Vld = 1'b0; Din = '0; Drdy = 1'b1;
`ifdef NCO_OBUF_DECIM_EN
        Dec = 4'd0;
`endif
        #22;
        chk("reset_dvld", Dvld, 0);
        chk("reset_dout", Dout, 0);
        chk("reset_sof", Sof, 0);
        chk("reset_level", Level, 0);
        chk("reset_ovf", Ovf, 0);
        rstn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].vld, vecs[i].din, vecs[i].drdy, 1'b0);
            chk($sformatf("vec%0d_dvld", i), Dvld, vecs[i].exp_dvld);
            if (vecs[i].exp_dvld) chk($sformatf("vec%0d_dout", i), Dout, vecs[i].exp_dout);
            chk($sformatf("vec%0d_sof", i), Sof, vecs[i].exp_sof);
            chk($sformatf("vec%0d_level", i), Level, vecs[i].exp_level);
            chk($sformatf("vec%0d_ovf", i), Ovf, vecs[i].exp_ovf);
        end

        // Stall: nibble A held with Sof for 5 cycles, then completes.
        cyc(1, 12'hA5C, 0, 0);
        chk("stall_level", Level, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            chk($sformatf("stall%0d_dvld", i), Dvld, 1);
            chk($sformatf("stall%0d_dout", i), Dout, 4'hA);
            chk($sformatf("stall%0d_sof", i), Sof, 1);
        end
        cyc(0, 0, 1, 0);
        chk("stall_n1", Dout, 4'h5);
        cyc(0, 0, 1, 0);
        chk("stall_n2", Dout, 4'hC);
        cyc(0, 0, 1, 0);
        chk("stall_done", Dvld, 0);

        // Overflow: ten samples with sink blocked.
        for (int k = 1; k <= 10; k++) begin
            cyc(1, 12'(k), 0, 0);
            if (k == 9) begin
                chk("ovf_level9", Level, 8);
                chk("ovf_pre", Ovf, 0);
            end
        end
        chk("ovf_level10", Level, 8);
        chk("ovf_set", Ovf, 1);
        chk("ovf_dvld", Dvld, 1);
        chk("ovf_sof", Sof, 1);
        Vld = 1'b0; Drdy = 1'b1;
        collect(60, 9, n, got);
        chk("drain_count", n, 9);
        for (int k = 0; k < 9 && k < n; k++) chk($sformatf("drain%0d", k), got[k], k + 1);
        chk("drain_ovf", Ovf, 1);
        cyc(0, 0, 1, 0);
        chk("drain_idle", Dvld, 0);

        // Flush mid-sample with Vld in the same cycle.
        cyc(1, 12'hABC, 0, 0);
        cyc(1, 12'hDEF, 0, 0);
        cyc(1, 12'h123, 0, 0);
        cyc(1, 12'h456, 0, 0);
        chk("clr_pre_level", Level, 3);
        chk("clr_pre_dout", Dout, 4'hA);
        cyc(0, 0, 1, 0);
        chk("clr_nib1", Dout, 4'hB);
        chk("clr_nib1_sof", Sof, 0);
        cyc(1, 12'h777, 1, 1);
        chk("clr_dvld", Dvld, 0);
        chk("clr_level", Level, 0);
        chk("clr_ovf", Ovf, 0);
        cyc(0, 0, 1, 0);
        chk("clr_nopush_level", Level, 0);
        chk("clr_nopush_dvld", Dvld, 0);

        // Async reset mid-transfer.
        cyc(1, 12'h9F1, 1, 0);
        cyc(1, 12'h222, 1, 0);
        chk("arst_pre_dout", Dout, 4'h9);
        chk("arst_pre_level", Level, 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_dvld", Dvld, 0);
        chk("arst_dout", Dout, 0);
        chk("arst_sof", Sof, 0);
        chk("arst_level", Level, 0);
        chk("arst_ovf", Ovf, 0);
        #1 rstn = 1'b1;
        cyc(0, 0, 1, 0);
        chk("arst_post_dvld", Dvld, 0);
        chk("arst_post_level", Level, 0);

`ifdef NCO_OBUF_DECIM_EN
        // Decimate by 3: continuous Vld 0..8 keeps samples 0, 3, 6.
        Dec = 4'd2;
        n = 0;
        begin
            logic [11:0] cur;
            int k;
            cur = '0; k = 0;
            for (int i = 0; i < 24; i++) begin
                if (Dvld) begin
                    cur = {cur[7:0], Dout};
                    k++;
                    if (k == 3) begin
                        if (n < 16) got[n] = cur;
                        n++;
                        k = 0;
                    end
                end
                cyc(i < 9, 12'(i), 1, 0);
            end
        end
        chk("dec_count", n, 3);
        for (int k = 0; k < 3 && k < n; k++) chk($sformatf("dec%0d", k), got[k], 3 * k);
        chk("dec_ovf", Ovf, 0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
